// File: rtl/regfile_read_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// regfile_read_scoreboard_pkg
//   Shared ISA definitions for the register-file access logic: opcode
//   constants, architecturally special register indices and the decoded
//   register-access record passed from the access decoder to the scoreboard.
//   No ports (package).
// ---------------------------------------------------------------------------
package regfile_read_scoreboard_pkg;

  typedef logic [4:0] opcode_t;
  typedef logic [4:0] reg_idx_t;

  // Opcodes, instruction bits [31:27]
  localparam opcode_t OP_ALU  = 5'b00000;
  localparam opcode_t OP_J    = 5'b00001;
  localparam opcode_t OP_BNE  = 5'b00010;
  localparam opcode_t OP_JAL  = 5'b00011;
  localparam opcode_t OP_JR   = 5'b00100;
  localparam opcode_t OP_ADDI = 5'b00101;
  localparam opcode_t OP_BLT  = 5'b00110;
  localparam opcode_t OP_SW   = 5'b00111;
  localparam opcode_t OP_LW   = 5'b01000;
  localparam opcode_t OP_SETX = 5'b10101;
  localparam opcode_t OP_BEX  = 5'b10110;

  // Implicit registers
  localparam reg_idx_t R_ZERO   = 5'd0;
  localparam reg_idx_t R_STATUS = 5'd30;
  localparam reg_idx_t R_LINK   = 5'd31;

  // Which registers one instruction reads and writes
  typedef struct packed {
    reg_idx_t src_a;
    logic     src_a_valid;
    reg_idx_t src_b;
    logic     src_b_valid;
    reg_idx_t dest;
    logic     dest_valid;
  } access_t;

  function automatic opcode_t insn_opcode(input logic [31:0] insn);
    return insn[31:27];
  endfunction

endpackage

// File: rtl/regfile_read_scoreboard_access_decode.sv
// ---------------------------------------------------------------------------
// regfile_access_decode
//   Purely combinational decode of an instruction into the registers it
//   reads (up to two) and the register it writes (at most one).
//   Ports:
//     insn_i    in  32  instruction: [31:27] opcode, [26:22] rd, [21:17] rs,
//                       [16:12] rt
//     access_o  out     decoded sources/destination with valid flags;
//                       a destination of r0 is reported as no destination
// ---------------------------------------------------------------------------
module regfile_access_decode
  import regfile_read_scoreboard_pkg::*;
(
  input  logic [31:0] insn_i,
  output access_t     access_o
);

  reg_idx_t rd;
  reg_idx_t rs;
  reg_idx_t rt;
  logic     unused_imm;

  assign rd = insn_i[26:22];
  assign rs = insn_i[21:17];
  assign rt = insn_i[16:12];
  // Immediate / target field carries no register information
  assign unused_imm = ^insn_i[11:0];

  always_comb begin
    access_o = '0;
    case (insn_opcode(insn_i))
      OP_ALU: begin
        access_o.dest        = rd;
        access_o.dest_valid  = 1'b1;
        access_o.src_a       = rs;
        access_o.src_a_valid = 1'b1;
        access_o.src_b       = rt;
        access_o.src_b_valid = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        access_o.dest        = rd;
        access_o.dest_valid  = 1'b1;
        access_o.src_a       = rs;
        access_o.src_a_valid = 1'b1;
      end
      OP_JAL: begin
        access_o.dest        = R_LINK;
        access_o.dest_valid  = 1'b1;
      end
      OP_SETX: begin
        access_o.dest        = R_STATUS;
        access_o.dest_valid  = 1'b1;
      end
      // Stores and branches read the rd field as a source
      OP_SW, OP_BNE, OP_BLT: begin
        access_o.src_a       = rd;
        access_o.src_a_valid = 1'b1;
        access_o.src_b       = rs;
        access_o.src_b_valid = 1'b1;
      end
      OP_JR: begin
        access_o.src_a       = rd;
        access_o.src_a_valid = 1'b1;
      end
      OP_BEX: begin
        access_o.src_a       = R_STATUS;
        access_o.src_a_valid = 1'b1;
      end
      default: ;  // j and undefined opcodes touch no registers
    endcase
    // Writes to r0 are architecturally discarded, so never track them
    if (access_o.dest == R_ZERO) begin
      access_o.dest_valid = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_read_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_read_scoreboard
//   Decode/issue RAW-hazard scoreboard. Counts in-flight writes per register
//   and holds an instruction in decode until all its sources are written back
//   (or are being written back this cycle).
//   Ports:
//     clock         in   1   rising-edge clock
//     reset_n       in   1   asynchronous active-low reset
//     id_valid      in   1   decode presents an instruction
//     id_insn       in   32  instruction word
//     id_stall      out  1   issue blocked this cycle (combinational)
//     id_fire       out  1   instruction leaves decode this cycle
//     wb_valid      in   1   writeback commits a register write
//     wb_rd         in   5   writeback destination
//     pending_mask  out  N   bit i set while register i has writes in flight
//     wb_underflow  out  1   sticky: writeback to a register with none pending
// ---------------------------------------------------------------------------
module regfile_read_scoreboard
  import regfile_read_scoreboard_pkg::*;
#(
  parameter int CNT_W    = 2,
  parameter int NUM_REGS = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [31:0]         id_insn,
  output logic                id_stall,
  output logic                id_fire,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                wb_underflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  access_t acc;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_d;
  logic [NUM_REGS-1:0]            pending_q;
  logic [NUM_REGS-1:0]            pending_d;
  logic                           underflow_q;
  logic                           underflow_d;

  logic src_a_busy;
  logic src_b_busy;
  logic dest_full;

  regfile_access_decode u_decode (
    .insn_i   (id_insn),
    .access_o (acc)
  );

  // A source is clear if its last outstanding write commits this cycle:
  // the register file writes in the first half and reads in the second.
  assign src_a_busy = acc.src_a_valid && (acc.src_a != R_ZERO)
                      && (cnt_q[acc.src_a] != '0)
                      && !(wb_valid && (wb_rd == acc.src_a)
                           && (cnt_q[acc.src_a] == CNT_ONE));
  assign src_b_busy = acc.src_b_valid && (acc.src_b != R_ZERO)
                      && (cnt_q[acc.src_b] != '0)
                      && !(wb_valid && (wb_rd == acc.src_b)
                           && (cnt_q[acc.src_b] == CNT_ONE));

  // A full counter only blocks a new write if no writeback drains it in the
  // same cycle; then the increment and decrement cancel and it holds at max.
  assign dest_full = acc.dest_valid && (cnt_q[acc.dest] == CNT_MAX)
                     && !(wb_valid && (wb_rd == acc.dest));

  assign id_stall = id_valid && (src_a_busy || src_b_busy || dest_full);
  assign id_fire  = id_valid && !id_stall;

  // Per-register counter next-state
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign cnt_d[gi]     = '0;
      assign pending_d[gi] = 1'b0;
    end else begin : g_cnt
      logic inc;
      logic dec;
      assign inc = id_fire && acc.dest_valid && (acc.dest == 5'(gi));
      assign dec = wb_valid && (wb_rd == 5'(gi)) && (cnt_q[gi] != '0);
      assign cnt_d[gi] = (inc && !dec) ? cnt_q[gi] + CNT_ONE :
                         (dec && !inc) ? cnt_q[gi] - CNT_ONE :
                                         cnt_q[gi];
      assign pending_d[gi] = |cnt_d[gi];
    end
  end

  assign underflow_d = underflow_q
                       || (wb_valid && (wb_rd != R_ZERO) && (cnt_q[wb_rd] == '0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      pending_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      underflow_q <= underflow_d;
    end
  end

  assign pending_mask = pending_q;
  assign wb_underflow = underflow_q;

endmodule

// File: tb/tb_regfile_read_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_read_scoreboard
//   Directed scenarios plus randomized traffic against a counting model of
//   outstanding writes per register.
// ---------------------------------------------------------------------------
module tb_regfile_read_scoreboard;

  localparam logic [4:0] OP_ALU = 5'b00000, OP_J = 5'b00001, OP_BNE = 5'b00010,
                         OP_JAL = 5'b00011, OP_JR = 5'b00100, OP_ADDI = 5'b00101,
                         OP_BLT = 5'b00110, OP_SW = 5'b00111, OP_LW = 5'b01000,
                         OP_SETX = 5'b10101, OP_BEX = 5'b10110, OP_UNDEF = 5'b11111;

  logic        clock;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_insn;
  logic        id_stall;
  logic        id_fire;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] pending_mask;
  logic        wb_underflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference: number of outstanding writes per register, sticky error
  int unsigned mcnt[32];
  bit          m_uf;

  regfile_read_scoreboard #(.CNT_W(2), .NUM_REGS(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_insn      (id_insn),
    .id_stall     (id_stall),
    .id_fire      (id_fire),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .pending_mask (pending_mask),
    .wb_underflow (wb_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  // ---------------- reference model ----------------
  function automatic void m_dest(input logic [31:0] insn, output int d, output bit v);
    case (insn[31:27])
      OP_ALU, OP_ADDI, OP_LW: d = int'(insn[26:22]);
      OP_JAL:                 d = 31;
      OP_SETX:                d = 30;
      default:                d = 0;
    endcase
    v = (d != 0);
  endfunction

  function automatic bit [31:0] m_srcs(input logic [31:0] insn);
    bit [31:0] s;
    s = '0;
    case (insn[31:27])
      OP_ALU:                begin s[insn[21:17]] = 1'b1; s[insn[16:12]] = 1'b1; end
      OP_ADDI, OP_LW:        s[insn[21:17]] = 1'b1;
      OP_SW, OP_BNE, OP_BLT: begin s[insn[26:22]] = 1'b1; s[insn[21:17]] = 1'b1; end
      OP_JR:                 s[insn[26:22]] = 1'b1;
      OP_BEX:                s[30] = 1'b1;
      default:               ;
    endcase
    return s;
  endfunction

  function automatic bit m_stall();
    bit [31:0] s;
    int d;
    bit dv;
    bit st;
    st = 0;
    if (!id_valid) return 0;
    s = m_srcs(id_insn);
    for (int r = 1; r < 32; r++)
      if (s[r] && mcnt[r] > 0 && !(wb_valid && int'(wb_rd) == r && mcnt[r] == 1)) st = 1;
    m_dest(id_insn, d, dv);
    if (dv && mcnt[d] == 3 && !(wb_valid && int'(wb_rd) == d)) st = 1;
    return st;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) m[r] = (mcnt[r] != 0);
    return m;
  endfunction

  // ---------------- stimulus plumbing ----------------
  task automatic apply_reset();
    reset_n = 1'b0; id_valid = 0; id_insn = '0; wb_valid = 0; wb_rd = '0;
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    m_uf = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Present inputs just after a rising edge, return at the falling edge
  task automatic drive(input bit v, input logic [31:0] insn, input bit wv, input logic [4:0] wr);
    id_valid = v; id_insn = insn; wb_valid = wv; wb_rd = wr;
    @(negedge clock);
  endtask

  // Advance the model with the held inputs, then take the rising edge
  task automatic tick();
    bit f;
    int d;
    bit dv;
    int unsigned pre;
    f = id_valid && !m_stall();
    $display("cyc %0d v=%b insn=%h wb=%b/%0d stall=%b fire=%b mask=%h uf=%b",
             cyc, id_valid, id_insn, wb_valid, wb_rd, id_stall, id_fire, pending_mask, wb_underflow);
    pre = (wb_valid && wb_rd != 0) ? mcnt[wb_rd] : 0;
    if (f) begin
      m_dest(id_insn, d, dv);
      if (dv) mcnt[d]++;
    end
    if (wb_valid && wb_rd != 0) begin
      if (pre > 0) mcnt[wb_rd]--;
      else m_uf = 1;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; id_valid = 0; id_insn = '0; wb_valid = 0; wb_rd = '0;
    #12;
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", pending_mask); end
    checks++; if (wb_underflow !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b want 0", wb_underflow); end
    checks++; if (id_stall !== 1'b0 || id_fire !== 1'b0) begin errors++; $display("FAIL reset_idle: stall=%b fire=%b want 0/0", id_stall, id_fire); end
    apply_reset();
  endtask

  task automatic test_raw_stall();
    logic [31:0] add_i;
    apply_reset();
    add_i = enc(OP_ALU, 5'd2, 5'd1, 5'd1);
    drive(1, enc(OP_ADDI, 5'd1, 5'd0, 5'd0), 0, 0);
    checks++; if (id_fire !== 1'b1) begin errors++; $display("FAIL raw_addi_fire: got %b want 1", id_fire); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, add_i, 0, 0);
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", id_stall); end
      checks++; if (pending_mask !== 32'h2) begin errors++; $display("FAIL raw_mask_r1: got %h want 2", pending_mask); end
      tick();
    end
    drive(1, add_i, 1, 5'd1);
    checks++; if (id_stall !== 1'b0 || id_fire !== 1'b1) begin errors++; $display("FAIL raw_wb_release: stall=%b fire=%b want 0/1", id_stall, id_fire); end
    tick();
    drive(0, '0, 0, 0);
    checks++; if (pending_mask !== 32'h4) begin errors++; $display("FAIL raw_mask_r2: got %h want 4", pending_mask); end
    tick();
  endtask

  task automatic test_saturation();
    logic [31:0] lw5;
    apply_reset();
    lw5 = enc(OP_LW, 5'd5, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, lw5, 0, 0);
      checks++; if (id_fire !== 1'b1) begin errors++; $display("FAIL sat_fire%0d: got %b want 1", i, id_fire); end
      tick();
    end
    drive(1, lw5, 0, 0);
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL sat_full_stall: got %b want 1", id_stall); end
    tick();
    drive(1, lw5, 1, 5'd5);
    checks++; if (id_fire !== 1'b1) begin errors++; $display("FAIL sat_wb_fire: got %b want 1", id_fire); end
    tick();
    // counter must still be at three: another write to r5 stalls
    drive(1, lw5, 0, 0);
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL sat_hold3: got %b want 1", id_stall); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 5'd5);
      tick();
    end
    drive(0, '0, 0, 0);
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL sat_drain: got %h want 0", pending_mask); end
    checks++; if (wb_underflow !== 1'b0) begin errors++; $display("FAIL sat_uf: got %b want 0", wb_underflow); end
    tick();
  endtask

  task automatic test_r0();
    apply_reset();
    drive(1, enc(OP_ALU, 5'd0, 5'd1, 5'd2), 0, 0);
    checks++; if (id_fire !== 1'b1) begin errors++; $display("FAIL r0_fire: got %b want 1", id_fire); end
    tick();
    drive(0, '0, 1, 5'd0);
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL r0_mask: got %h want 0", pending_mask); end
    tick();
    drive(1, enc(OP_ALU, 5'd3, 5'd0, 5'd0), 0, 0);
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL r0_read: got %b want 0", id_stall); end
    checks++; if (wb_underflow !== 1'b0) begin errors++; $display("FAIL r0_uf: got %b want 0", wb_underflow); end
    tick();
    drive(0, '0, 1, 5'd3);
    checks++; if (pending_mask !== 32'h8) begin errors++; $display("FAIL r0_mask_r3: got %h want 8", pending_mask); end
    tick();
  endtask

  task automatic test_link_status();
    apply_reset();
    drive(1, enc(OP_JAL, 5'd0, 5'd0, 5'd0), 0, 0); tick();
    drive(1, enc(OP_JR, 5'd31, 5'd0, 5'd0), 0, 0);
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL jr_stall: got %b want 1", id_stall); end
    checks++; if (pending_mask !== 32'h8000_0000) begin errors++; $display("FAIL jal_mask: got %h want 80000000", pending_mask); end
    tick();
    drive(1, enc(OP_JR, 5'd31, 5'd0, 5'd0), 1, 5'd31);
    checks++; if (id_fire !== 1'b1) begin errors++; $display("FAIL jr_release: got %b want 1", id_fire); end
    tick();
    drive(1, enc(OP_SETX, 5'd0, 5'd0, 5'd0), 0, 0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, enc(OP_BEX, 5'd0, 5'd0, 5'd0), 0, 0);
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL bex_stall: got %b want 1", id_stall); end
      tick();
    end
    drive(1, enc(OP_BEX, 5'd0, 5'd0, 5'd0), 1, 5'd30);
    checks++; if (id_fire !== 1'b1) begin errors++; $display("FAIL bex_release: got %b want 1", id_fire); end
    tick();
  endtask

  task automatic test_underflow();
    apply_reset();
    drive(0, '0, 1, 5'd7); tick();
    drive(0, '0, 0, 0);
    checks++; if (wb_underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b want 1", wb_underflow); end
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL uf_mask: got %h want 0", pending_mask); end
    tick();
    drive(0, '0, 0, 0);
    checks++; if (wb_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b want 1", wb_underflow); end
    tick();
  endtask

  task automatic test_reset_midstall();
    apply_reset();
    drive(0, '0, 1, 5'd7); tick();
    drive(1, enc(OP_ADDI, 5'd1, 5'd0, 5'd0), 0, 0); tick();
    drive(1, enc(OP_ADDI, 5'd2, 5'd0, 5'd0), 0, 0); tick();
    drive(1, enc(OP_ALU, 5'd3, 5'd1, 5'd2), 0, 0);
    checks++; if (pending_mask !== 32'h6 || id_stall !== 1'b1) begin errors++; $display("FAIL mid_pre: mask=%h stall=%b want 6/1", pending_mask, id_stall); end
    reset_n = 1'b0;
    #1;
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL mid_mask: got %h want 0", pending_mask); end
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b want 0", id_stall); end
    checks++; if (wb_underflow !== 1'b0) begin errors++; $display("FAIL mid_uf: got %b want 0", wb_underflow); end
    apply_reset();
  endtask

  task automatic test_random();
    logic [4:0] ops[12];
    logic [31:0] insn;
    bit held;
    bit wv;
    logic [4:0] wr;
    ops = '{OP_ALU, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI, OP_BLT, OP_SW, OP_LW, OP_SETX, OP_BEX, OP_UNDEF};
    apply_reset();
    held = 0;
    insn = '0;
    for (int n = 0; n < 400; n++) begin
      if (!held)
        insn = enc(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 6)),
                   5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)));
      wv = ($urandom_range(0, 9) < 4);
      wr = 5'($urandom_range(0, 7));
      if (wv && mcnt[wr] == 0 && $urandom_range(0, 7) != 0) begin
        for (int r = 1; r < 32; r++) if (mcnt[r] != 0) wr = 5'(r);
      end
      drive(held || ($urandom_range(0, 3) != 0), insn, wv, wr);
      held = m_stall();
      checks++; if (id_stall !== held) begin errors++; $display("FAIL rnd_stall n=%0d: got %b want %b", n, id_stall, held); end
      checks++; if (id_fire !== (id_valid && !held)) begin errors++; $display("FAIL rnd_fire n=%0d: got %b want %b", n, id_fire, id_valid && !held); end
      checks++; if (pending_mask !== m_mask()) begin errors++; $display("FAIL rnd_mask n=%0d: got %h want %h", n, pending_mask, m_mask()); end
      checks++; if (wb_underflow !== m_uf) begin errors++; $display("FAIL rnd_uf n=%0d: got %b want %b", n, wb_underflow, m_uf); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_saturation();
    test_r0();
    test_link_status();
    test_underflow();
    test_reset_midstall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
